// File: rtl/inst_buffer_if.sv
// Fetch/decode handshake bundle for the instruction packet buffer.
// The master side is whoever drives fetch packets and decode readiness;
// the slave side is the buffer itself.
interface inst_buffer_if #(
    parameter int DEPTH         = 4,
    parameter int CPU_ADDR_BITS = 32,
    parameter int CPU_INST_BITS = 32
);
    logic                         flush;
    logic                         fetch_val;
    logic                         fetch_rdy;
    logic [CPU_ADDR_BITS-1:0]     fetch_pc0;
    logic [CPU_ADDR_BITS-1:0]     fetch_pc1;
    logic [CPU_INST_BITS-1:0]     fetch_inst0;
    logic [CPU_INST_BITS-1:0]     fetch_inst1;
    logic                         decode_rdy;
    logic                         inst_val;
    logic [CPU_ADDR_BITS-1:0]     inst0_pc;
    logic [CPU_ADDR_BITS-1:0]     inst1_pc;
    logic [CPU_INST_BITS-1:0]     inst0;
    logic [CPU_INST_BITS-1:0]     inst1;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output flush, fetch_val, fetch_pc0, fetch_pc1, fetch_inst0, fetch_inst1,
               decode_rdy,
        input  fetch_rdy, inst_val, inst0_pc, inst1_pc, inst0, inst1, count
    );

    modport slave (
        input  flush, fetch_val, fetch_pc0, fetch_pc1, fetch_inst0, fetch_inst1,
               decode_rdy,
        output fetch_rdy, inst_val, inst0_pc, inst1_pc, inst0, inst1, count
    );
endinterface

// File: rtl/inst_buffer.sv
// Two-wide instruction packet FIFO sitting between fetch and decode.
// Each entry holds a whole packet (two PCs, two instructions) so the two
// slots always travel together. No bypass: a pushed packet becomes visible
// one cycle later. Flush and reset both discard everything.
module inst_buffer #(
    parameter int DEPTH         = 4,
    parameter int CPU_ADDR_BITS = 32,
    parameter int CPU_INST_BITS = 32
) (
    input logic        clk,
    input logic        rst,
    inst_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [CPU_ADDR_BITS-1:0] mem_pc0   [DEPTH];
    logic [CPU_ADDR_BITS-1:0] mem_pc1   [DEPTH];
    logic [CPU_INST_BITS-1:0] mem_inst0 [DEPTH];
    logic [CPU_INST_BITS-1:0] mem_inst1 [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;

    logic full;
    logic empty;
    logic push;
    logic pop;

    // Handshake decode; a full buffer refuses fetch even when decode pops this cycle.
    always_comb begin
        full          = (count_q == FULL_CNT);
        empty         = (count_q == '0);
        bus.fetch_rdy = ~rst & ~bus.flush & ~full;
        bus.inst_val  = ~empty;
        push          = bus.fetch_val & bus.fetch_rdy;
        pop           = bus.inst_val & bus.decode_rdy;
    end

    // Pointer and occupancy bookkeeping; reset and flush both clear it all.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Packet payload storage; not reset, since validity comes from the count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc0[wr_ptr]   <= bus.fetch_pc0;
            mem_pc1[wr_ptr]   <= bus.fetch_pc1;
            mem_inst0[wr_ptr] <= bus.fetch_inst0;
            mem_inst1[wr_ptr] <= bus.fetch_inst1;
        end
    end

    // Head packet presented to decode, forced to zero while nothing is held.
    always_comb begin
        bus.count    = count_q;
        bus.inst0_pc = '0;
        bus.inst1_pc = '0;
        bus.inst0    = '0;
        bus.inst1    = '0;
        if (!empty) begin
            bus.inst0_pc = mem_pc0[rd_ptr];
            bus.inst1_pc = mem_pc1[rd_ptr];
            bus.inst0    = mem_inst0[rd_ptr];
            bus.inst1    = mem_inst1[rd_ptr];
        end
    end
endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for the instruction packet buffer.
module tb_inst_buffer;
    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    inst_buffer_if #(.DEPTH(4), .CPU_ADDR_BITS(32), .CPU_INST_BITS(32)) bus ();

    inst_buffer #(.DEPTH(4), .CPU_ADDR_BITS(32), .CPU_INST_BITS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so a broken design can never stall the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] instA(input logic [31:0] pc);
        return {16'hbeef, pc[15:0]};
    endfunction

    function automatic logic [31:0] instB(input logic [31:0] pc);
        return {16'hcafe, pc[15:0]};
    endfunction

    // Drive one cycle's worth of inputs; the packet derives from its slot-0 PC.
    task automatic applyStimulus(input logic fv, input logic [31:0] pc,
                                 input logic drdy, input logic fl);
        bus.fetch_val   = fv;
        bus.fetch_pc0   = pc;
        bus.fetch_pc1   = pc + 32'd4;
        bus.fetch_inst0 = instA(pc);
        bus.fetch_inst1 = instB(pc);
        bus.decode_rdy  = drdy;
        bus.flush       = fl;
        #1;
    endtask

    // Compare the whole head packet against the one built from pc.
    task automatic checkHead(input string tag, input logic [31:0] pc);
        checkOutput({tag, "_val"},   64'(bus.inst_val), 64'd1);
        checkOutput({tag, "_pc0"},   64'(bus.inst0_pc), 64'(pc));
        checkOutput({tag, "_pc1"},   64'(bus.inst1_pc), 64'(pc + 32'd4));
        checkOutput({tag, "_inst0"}, 64'(bus.inst0),    64'(instA(pc)));
        checkOutput({tag, "_inst1"}, 64'(bus.inst1),    64'(instB(pc)));
    endtask

    task automatic checkEmpty(input string tag);
        checkOutput({tag, "_val"},   64'(bus.inst_val), 64'd0);
        checkOutput({tag, "_count"}, 64'(bus.count),    64'd0);
        checkOutput({tag, "_pc0"},   64'(bus.inst0_pc), 64'd0);
        checkOutput({tag, "_pc1"},   64'(bus.inst1_pc), 64'd0);
        checkOutput({tag, "_inst0"}, 64'(bus.inst0),    64'd0);
        checkOutput({tag, "_inst1"}, 64'(bus.inst1),    64'd0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
        tick();
        tick();

        // Reset state
        checkOutput("rst_fetch_rdy", 64'(bus.fetch_rdy), 64'd0);
        checkEmpty("rst");
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("post_rst_rdy", 64'(bus.fetch_rdy), 64'd1);

        // Single packet: 1-cycle latency, stable while decode stalls, then popped
        bus.fetch_val   = 1'b1;
        bus.fetch_pc0   = 32'h100;
        bus.fetch_pc1   = 32'h104;
        bus.fetch_inst0 = 32'h00500093;
        bus.fetch_inst1 = 32'h00a00113;
        bus.decode_rdy  = 1'b0;
        #1;
        checkOutput("single_not_bypassed", 64'(bus.inst_val), 64'd0);
        tick();
        bus.fetch_val = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("single_val",   64'(bus.inst_val), 64'd1);
            checkOutput("single_pc0",   64'(bus.inst0_pc), 64'h100);
            checkOutput("single_pc1",   64'(bus.inst1_pc), 64'h104);
            checkOutput("single_inst0", 64'(bus.inst0),    64'h00500093);
            checkOutput("single_inst1", 64'(bus.inst1),    64'h00a00113);
            checkOutput("single_count", 64'(bus.count),    64'd1);
            if (i < 3) tick();
        end
        bus.decode_rdy = 1'b1;
        tick();
        bus.decode_rdy = 1'b0;
        #1;
        checkEmpty("single_popped");

        // Fill to capacity, a fifth offer is held off, then drain in order
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h200 + 32'(8 * i), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 32'h220, 1'b0, 1'b0);
        checkOutput("full_count", 64'(bus.count),     64'd4);
        checkOutput("full_rdy",   64'(bus.fetch_rdy), 64'd0);
        tick();
        checkOutput("full_held_count", 64'(bus.count), 64'd4);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkHead("drain", 32'h200 + 32'(8 * i));
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkEmpty("drained");

        // Streaming: one packet per cycle, pointers wrap three times
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, 32'h300 + 32'(8 * k), 1'b1, 1'b0);
            if (k > 0) begin
                checkOutput("stream_pc0",   64'(bus.inst0_pc),  64'(32'h300 + 32'(8 * (k - 1))));
                checkOutput("stream_inst1", 64'(bus.inst1),     64'(instB(32'h300 + 32'(8 * (k - 1)))));
                checkOutput("stream_count", 64'(bus.count),     64'd1);
                checkOutput("stream_rdy",   64'(bus.fetch_rdy), 64'd1);
            end
            tick();
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkHead("stream_last", 32'h300 + 32'd88);
        checkOutput("stream_last_count", 64'(bus.count), 64'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("stream_empty", 64'(bus.inst_val), 64'd0);

        // Full with a pop: no same-cycle refill, push accepted the cycle after
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h400 + 32'(8 * i), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 32'h420, 1'b1, 1'b0);
        checkOutput("fullpop_rdy", 64'(bus.fetch_rdy), 64'd0);
        checkHead("fullpop_head", 32'h400);
        tick();
        checkOutput("fullpop_count", 64'(bus.count),     64'd3);
        checkOutput("refill_rdy",    64'(bus.fetch_rdy), 64'd1);
        checkHead("fullpop_next", 32'h408);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("refill_count", 64'(bus.count), 64'd3);
        checkHead("refill_head", 32'h410);

        // Flush at count=3 with push and pop offered
        applyStimulus(1'b1, 32'h500, 1'b1, 1'b1);
        checkOutput("flush_rdy", 64'(bus.fetch_rdy), 64'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkEmpty("flushed");
        applyStimulus(1'b1, 32'h508, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("postflush_count", 64'(bus.count), 64'd1);
        checkHead("postflush_head", 32'h508);
        applyStimulus(1'b1, 32'h510, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("prerst_count", 64'(bus.count), 64'd2);

        // Reset at count=2 together with flush and a fetch offer
        rst = 1'b1;
        applyStimulus(1'b1, 32'h600, 1'b0, 1'b1);
        checkOutput("midrst_rdy", 64'(bus.fetch_rdy), 64'd0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkEmpty("midrst");
        checkOutput("midrst_after_rdy", 64'(bus.fetch_rdy), 64'd1);
        applyStimulus(1'b1, 32'h608, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("postrst_count", 64'(bus.count), 64'd1);
        checkHead("postrst_head", 32'h608);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkEmpty("postrst_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
Two-wide instruction packet FIFO between fetch and decode. Absorbs fetched packets (2 PCs + 2 instructions) while decode back-pressures. Presents the head packet to decode with a single valid. Discards all contents on pipeline flush.

Parameters:
- DEPTH, 4, number of packet entries; power of 2, >= 2.
- CPU_ADDR_BITS, 32, PC width (from uarch_pkg).
- CPU_INST_BITS, 32, instruction width (from uarch_pkg).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- flush  input  1  synchronous discard of all buffered packets.
- fetch_val  input  1  fetch offers a packet this cycle.
- fetch_rdy  output  1  buffer accepts a packet this cycle.
- fetch_pc0, fetch_pc1  input  CPU_ADDR_BITS  PCs of slot 0 / slot 1.
- fetch_inst0, fetch_inst1  input  CPU_INST_BITS  instructions of slot 0 / slot 1.
- decode_rdy  input  1  decode consumes the head packet this cycle.
- inst_val  output  1  head packet valid.
- inst0_pc, inst1_pc  output  CPU_ADDR_BITS  head packet PCs.
- inst0, inst1  output  CPU_INST_BITS  head packet instructions.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage: circular array of DEPTH entries {pc0, pc1, inst0, inst1}. Payload registers are not reset.
- State:
  - wr_ptr, rd_ptr: $clog2(DEPTH) bits each; wrap DEPTH-1 -> 0 by natural overflow.
  - count: 0..DEPTH.
- Ready/valid (all combinational):
  - full = (count == DEPTH); empty = (count == 0).
  - fetch_rdy = ~rst & ~flush & ~full.
  - inst_val = ~empty.
- push = fetch_val & fetch_rdy. It writes the entry at wr_ptr and advances wr_ptr.
- pop = inst_val & decode_rdy. It advances rd_ptr.
- count update: count_next = count + push - pop. Push and pop together leave count unchanged.
- Full with pop: fetch_rdy stays 0. No same-cycle refill. A push is accepted the following cycle.
- Empty: no bypass. A packet pushed in cycle N appears on the outputs with inst_val=1 in cycle N+1 (1-cycle latency). While empty, the inst0/inst1/pc outputs are driven to 0.
- Head outputs: combinational read of the entry at rd_ptr. They are stable while inst_val=1 and decode_rdy=0.
- Packets leave in strict FIFO order; slot 0 and slot 1 of a packet never separate.
- flush=1 (cycle N):
  - wr_ptr, rd_ptr and count are cleared to 0 at the edge.
  - The cycle-N push is blocked (fetch_rdy=0).
  - A cycle-N pop has no effect beyond the clear.
  - inst_val=0 from cycle N+1.
- rst=1: same clear as flush.
  - Reset values: count=0, inst_val=0, inst0/inst1/inst0_pc/inst1_pc=0.
  - fetch_rdy=0 while rst is high, and 1 in the first cycle after release.
  - rst takes priority over flush, push and pop. Reset asserted mid-stream drops all entries.
- No error conditions. Push while full and pop while empty cannot occur by construction.

Test Plan:
- Reset, then single push of {pc0=0x100, pc1=0x104, inst0=0x00500093, inst1=0x00a00113} with decode_rdy=0:
  - inst_val=1 next cycle with those exact values; count=1.
  - Holds stable for 3 cycles.
  - decode_rdy=1 pops it; inst_val=0 and count=0 the next cycle.
- Push 4 packets (PCs 0x200, 0x208, 0x210, 0x218) with decode_rdy=0:
  - count=4, fetch_rdy=0.
  - A 5th fetch_val is held off.
  - Draining with decode_rdy=1 yields 0x200, 0x208, 0x210, 0x218 in order.
- Continuous fetch_val=1 and decode_rdy=1 for 12 cycles:
  - Throughput of 1 packet/cycle after the first; count stays at 1.
  - Pointers wrap at least twice; output order matches input order.
- Full buffer, decode_rdy=1, fetch_val=1:
  - That cycle pops without pushing; count goes 4 -> 3.
  - The next cycle accepts the push; count stays 3.
- count=3, assert flush with fetch_val=1 and decode_rdy=1:
  - Next cycle count=0, inst_val=0, outputs=0.
  - The flush-cycle packet is not stored.
  - A push the following cycle appears as the sole entry.
- count=2, assert rst for 1 cycle together with flush and fetch_val:
  - fetch_rdy=0 during reset; afterwards count=0, inst_val=0, fetch_rdy=1.
  - Old packets are never presented.
